unflatten_buffer_loader: RTL and testbench
==========================================

// Module: unflatten_buffer_loader
// PURPOSE
//  Write-side counterpart of the flatten-buffer path. Accepts one numChannels-wide
//  word per valid cycle plus its delay/width tag. Shifts each word into a
//  (buff_depth+1)-deep history buffer, with index 0 holding the newest entry.
//  Tracks fill level and flags when the whole buffer holds live data. Its buffer and
//  buffer_delay outputs feed the slice flatteners that come after it in the DSP datapath.
// PARAMETERS
//  numChannels  16  words per push (one per channel)
//  bitwidth     8   bits per word
//  buff_depth   5   highest buffer index; buffer holds buff_depth+1 entries
//  delay_width  4   delay field width of the tag
//  width_width  4   width field width of the tag
// PORTS
//  clk           in   1                          clock, all state on rising edge
//  rst           in   1                          async active-high reset
//  in_valid      in   1                          push flat_in/flat_in_delay this cycle
//  flat_in       in   [bitwidth-1:0] x numChannels  incoming channel words
//  flat_in_delay in   delay_width+width_width    tag for this push
//  flush         in   1                          sync clear of contents and fill level
//  buffer        out  [bitwidth-1:0] [numChannels-1:0][buff_depth:0]  history, [ch][0] newest
//  buffer_delay  out  [dw+ww-1:0] [buff_depth:0] tag history, aligned with buffer
//  fill_count    out  $clog2(buff_depth+2)       number of live entries, 0..buff_depth+1
//  buffer_full   out  1                          fill_count == buff_depth+1
//  snap_strobe   out  1                          1-cycle pulse: push just landed while full
// BEHAVIOUR
//  - Reset (async, rst=1): buffer, buffer_delay, fill_count, buffer_full and snap_strobe
//    all go to 0 immediately. State is EMPTY.
//  - Push (in_valid=1, flush=0), for every ch and for k=buff_depth..1:
//    buffer[ch][k] <= buffer[ch][k-1], buffer[ch][0] <= flat_in[ch].
//    buffer_delay shifts identically. The oldest entry is discarded.
//  - No push: all contents hold.
//  - fill_count increments on a push and saturates at buff_depth+1. There is no wrap.
//  - State machine (registered):
//    EMPTY(count 0) -push-> FILLING (or FULL if buff_depth==0).
//    FILLING -push with count==buff_depth-> FULL.
//    FULL stays FULL on push.
//    Any state -flush-> EMPTY.
//  - buffer_full is registered and equals (state==FULL). It updates in the same edge as
//    the push that fills the buffer.
//  - snap_strobe is registered. It is 1 in the cycle after each push whose result state
//    is FULL, including the filling push. Otherwise 0. Continuous pushes while full
//    hold it high.
//  - flush=1 alone: all contents zeroed, fill_count=0, state EMPTY, snap_strobe=0.
//  - flush and in_valid together: clear, then load the new word at index 0.
//    Result: fill_count=1, indices 1..buff_depth=0, state FILLING
//    (FULL if buff_depth==0).
//  - Latency: a word is visible at buffer[*][0] one clk after its push.
//    It reaches index k after k further pushes.
//  - Reset asserted mid-fill discards everything. The first push after deassertion
//    gets fill_count=1.
//  - No backpressure: every valid cycle is accepted. in_valid with X data is a bench error.
// TESTING
//  1 Reset: assert rst mid-cycle -> all outputs 0 without waiting for a clk edge.
//    Release -> still 0.
//  2 Fill: 6 pushes, word n = 8'(n*16+ch), tag n.
//    -> after push 6: fill_count=6, buffer_full=1, buffer[ch][0]=0x50+ch,
//       buffer[ch][5]=0x00+ch, buffer_delay[5]=0, snap_strobe=1 exactly once so far.
//  3 Overflow: 2 more pushes (n=6,7) -> buffer[ch][5]=0x20+ch, fill_count stays 6,
//    snap_strobe high for both cycles.
//  4 Gaps: push, idle 3 cycles, push -> contents hold during idle, fill_count goes 1,1,1,1,2.
//  5 Flush+push: from FULL, flush=1 and in_valid=1 with word 0xAA -> fill_count=1,
//    buffer[ch][0]=0xAA, buffer[ch][1..5]=0, buffer_full=0, snap_strobe=0.
//  6 Reset mid-fill: 3 pushes, rst pulse, 1 push -> fill_count=1, only index 0 nonzero.

Source files
------------

// File: rtl/unflatten_buffer_loader.sv
// ============================================================================
// Module   : unflatten_buffer_loader
// Brief    : Shift-in history buffer of channel words and tags, newest at index 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module unflatten_buffer_loader #(
    parameter int NUM_CHANNELS = 16,
    parameter int BITWIDTH     = 8,
    parameter int BUFF_DEPTH   = 5,
    parameter int DELAY_WIDTH  = 4,
    parameter int WIDTH_WIDTH  = 4,
    localparam int TAG_W       = DELAY_WIDTH + WIDTH_WIDTH,
    localparam int CNT_W       = $clog2(BUFF_DEPTH + 2)
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               in_valid,
    input  logic [NUM_CHANNELS-1:0][BITWIDTH-1:0]              flat_in,
    input  logic [TAG_W-1:0]                                   flat_in_delay,
    input  logic                                               flush,
    output logic [NUM_CHANNELS-1:0][BUFF_DEPTH:0][BITWIDTH-1:0] buffer,
    output logic [BUFF_DEPTH:0][TAG_W-1:0]                     buffer_delay,
    output logic [CNT_W-1:0]                                   fill_count,
    output logic                                               buffer_full,
    output logic                                               snap_strobe
);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(BUFF_DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST_FILL  = CNT_W'(BUFF_DEPTH);
    localparam logic             DEPTH_ZERO = (BUFF_DEPTH == 0);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    state_t state;
    logic   lands_full;

    // A push lands full if the buffer already was full or this push fills it;
    // after a flush only a zero-depth buffer can be full with a single entry.
    always_comb begin
        lands_full = 1'b0;
        if (in_valid) begin
            if (flush) begin
                lands_full = DEPTH_ZERO;
            end else begin
                lands_full = (state == ST_FULL) || (fill_count == LAST_FILL);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buffer       <= '0;
            buffer_delay <= '0;
            fill_count   <= '0;
            buffer_full  <= 1'b0;
            snap_strobe  <= 1'b0;
            state        <= ST_EMPTY;
        end else begin
            snap_strobe <= lands_full;
            if (flush) begin
                buffer       <= '0;
                buffer_delay <= '0;
                if (in_valid) begin
                    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                        buffer[ch][0] <= flat_in[ch];
                    end
                    buffer_delay[0] <= flat_in_delay;
                    fill_count      <= CNT_W'(1);
                    state           <= DEPTH_ZERO ? ST_FULL : ST_FILLING;
                    buffer_full     <= DEPTH_ZERO;
                end else begin
                    fill_count  <= '0;
                    state       <= ST_EMPTY;
                    buffer_full <= 1'b0;
                end
            end else if (in_valid) begin
                for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                    for (int k = BUFF_DEPTH; k >= 1; k--) begin
                        buffer[ch][k] <= buffer[ch][k-1];
                    end
                    buffer[ch][0] <= flat_in[ch];
                end
                for (int k = BUFF_DEPTH; k >= 1; k--) begin
                    buffer_delay[k] <= buffer_delay[k-1];
                end
                buffer_delay[0] <= flat_in_delay;
                if (fill_count != FULL_COUNT) begin
                    fill_count <= fill_count + CNT_W'(1);
                end
                if (lands_full) begin
                    state       <= ST_FULL;
                    buffer_full <= 1'b1;
                end else begin
                    state       <= ST_FILLING;
                    buffer_full <= 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_unflatten_buffer_loader.sv
// ============================================================================
// Module   : tb_unflatten_buffer_loader
// Brief    : Directed and random bench for unflatten_buffer_loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_unflatten_buffer_loader;

    localparam int NCH = 16;
    localparam int BW  = 8;
    localparam int NE  = 6;
    localparam int TW  = 8;

    typedef logic [NCH-1:0][BW-1:0]         words_t;
    typedef logic [NCH-1:0][NE-1:0][BW-1:0] buf_t;
    typedef logic [NE-1:0][TW-1:0]          tags_t;
    typedef struct packed {
        words_t         words;
        logic [TW-1:0]  tag;
    } entry_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid = 1'b0;
    logic           flush = 1'b0;
    words_t         flat_in = '0;
    logic [TW-1:0]  flat_in_delay = '0;
    buf_t           buffer;
    tags_t          buffer_delay;
    logic [2:0]     fill_count;
    logic           buffer_full;
    logic           snap_strobe;

    int checks = 0;
    int errors = 0;
    int snap_seen = 0;

    unflatten_buffer_loader dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .flat_in       (flat_in),
        .flat_in_delay (flat_in_delay),
        .flush         (flush),
        .buffer        (buffer),
        .buffer_delay  (buffer_delay),
        .fill_count    (fill_count),
        .buffer_full   (buffer_full),
        .snap_strobe   (snap_strobe)
    );

    always #5 clk = ~clk;

    // Reference: the history is a queue of accepted pushes, newest first.
    entry_t hist[$];
    logic   m_snap = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist.delete();
            m_snap = 1'b0;
        end else begin
            if (flush) hist.delete();
            if (in_valid) begin
                hist.push_front('{words: flat_in, tag: flat_in_delay});
                if (hist.size() > NE) void'(hist.pop_back());
            end
            m_snap = in_valid && (hist.size() == NE);
        end
    end

    buf_t  exp_buf;
    tags_t exp_tag;
    logic [2:0] exp_cnt;

    always @(negedge clk) begin
        exp_buf = '0;
        exp_tag = '0;
        for (int k = 0; k < hist.size(); k++) begin
            for (int ch = 0; ch < NCH; ch++) exp_buf[ch][k] = hist[k].words[ch];
            exp_tag[k] = hist[k].tag;
        end
        exp_cnt = 3'(hist.size());
        checks += 5;
        if (buffer !== exp_buf) begin
            errors++;
            $display("FAIL buffer @%0t got %h want %h", $time, buffer, exp_buf);
        end
        if (buffer_delay !== exp_tag) begin
            errors++;
            $display("FAIL buffer_delay @%0t got %h want %h", $time, buffer_delay, exp_tag);
        end
        if (fill_count !== exp_cnt) begin
            errors++;
            $display("FAIL fill_count @%0t got %0d want %0d", $time, fill_count, exp_cnt);
        end
        if (buffer_full !== (hist.size() == NE)) begin
            errors++;
            $display("FAIL buffer_full @%0t got %b want %b", $time, buffer_full, hist.size() == NE);
        end
        if (snap_strobe !== m_snap) begin
            errors++;
            $display("FAIL snap_strobe @%0t got %b want %b", $time, snap_strobe, m_snap);
        end
        if (snap_strobe === 1'b1) snap_seen++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic words_t mk(input logic [7:0] base, input bit add_ch);
        words_t w;
        for (int ch = 0; ch < NCH; ch++) w[ch] = add_ch ? 8'(base + ch) : base;
        return w;
    endfunction

    // Called away from the rising edge; returns just after it with inputs idle.
    task automatic do_cycle(input logic v, input logic f, input words_t w, input logic [TW-1:0] t);
        in_valid      = v;
        flush         = f;
        flat_in       = w;
        flat_in_delay = t;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic settle;
        @(negedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_buf"},  64'(buffer == '0), 64'd1);
        chk({tag, "_dly"},  64'(buffer_delay == '0), 64'd1);
        chk({tag, "_cnt"},  64'(fill_count), 64'd0);
        chk({tag, "_full"}, 64'(buffer_full), 64'd0);
        chk({tag, "_snap"}, 64'(snap_strobe), 64'd0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #20 rst = 1'b0;
        settle();

        // Reset asserted mid-cycle clears outputs before any edge.
        do_cycle(1'b1, 1'b0, mk(8'h31, 1), 8'h3);
        do_cycle(1'b1, 1'b0, mk(8'h41, 1), 8'h4);
        #2 rst = 1'b1;
        #1 chk_all_zero("rst_async");
        @(posedge clk);
        #1 rst = 1'b0;
        settle();
        chk_all_zero("rst_release");

        // Fill
        snap_seen = 0;
        for (int n = 0; n < 6; n++) begin
            do_cycle(1'b1, 1'b0, mk(8'(n * 16), 1), 8'(n));
            settle();
        end
        chk("fill_cnt", 64'(fill_count), 64'd6);
        chk("fill_full", 64'(buffer_full), 64'd1);
        chk("fill_b0_ch3", 64'(buffer[3][0]), 64'h53);
        chk("fill_b5_ch9", 64'(buffer[9][5]), 64'h09);
        chk("fill_d5", 64'(buffer_delay[5]), 64'd0);
        chk("fill_snap_once", 64'(snap_seen), 64'd1);

        // Overflow
        for (int n = 6; n < 8; n++) begin
            do_cycle(1'b1, 1'b0, mk(8'(n * 16), 1), 8'(n));
            settle();
            chk("ovf_snap", 64'(snap_strobe), 64'd1);
        end
        chk("ovf_b5_ch7", 64'(buffer[7][5]), 64'h27);
        chk("ovf_cnt", 64'(fill_count), 64'd6);

        // Flush alone, then gaps
        do_cycle(1'b0, 1'b1, '0, '0);
        settle();
        chk_all_zero("flush");
        do_cycle(1'b1, 1'b0, mk(8'h90, 1), 8'h9);
        settle();
        chk("gap_cnt0", 64'(fill_count), 64'd1);
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b0, 1'b0, mk(8'hEE, 0), 8'hE);
            settle();
            chk("gap_cnt_idle", 64'(fill_count), 64'd1);
            chk("gap_hold", 64'(buffer[2][0]), 64'h92);
        end
        do_cycle(1'b1, 1'b0, mk(8'hA0, 1), 8'hA);
        settle();
        chk("gap_cnt2", 64'(fill_count), 64'd2);

        // Flush+push from full
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0, mk(8'(8'hB0 + i), 0), 8'(i));
        settle();
        chk("pre_flush_full", 64'(buffer_full), 64'd1);
        do_cycle(1'b1, 1'b1, mk(8'hAA, 0), 8'h5A);
        settle();
        chk("fp_cnt", 64'(fill_count), 64'd1);
        chk("fp_b0", 64'(buffer[11][0]), 64'hAA);
        chk("fp_rest", 64'(buffer[11][5:1] == '0), 64'd1);
        chk("fp_full", 64'(buffer_full), 64'd0);
        chk("fp_snap", 64'(snap_strobe), 64'd0);

        // Reset mid-fill
        do_cycle(1'b0, 1'b1, '0, '0);
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, mk(8'h60, 1), 8'h6);
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        do_cycle(1'b1, 1'b0, mk(8'h11, 1), 8'h1);
        settle();
        chk("rmf_cnt", 64'(fill_count), 64'd1);
        chk("rmf_b0", 64'(buffer[0][0]), 64'h11);
        chk("rmf_rest", 64'(buffer[15][5:1] == '0 && buffer_delay[5:1] == '0), 64'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            words_t w;
            for (int ch = 0; ch < NCH; ch++) w[ch] = 8'($urandom);
            do_cycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0), w, 8'($urandom));
        end
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
